// File: rtl/transmitter.sv
// transmitter: 8N1 UART transmit engine with a small byte FIFO.
// Bit timing comes from a 16x oversample clken tick.
module transmitter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       clken,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       tx,
  output logic       tx_busy,
  output logic       full,
  output logic       empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam bit TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  state_e        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [3:0]    sample_q, sample_d;
  logic [2:0]    bitpos_q, bitpos_d;
  logic          stop2_q, stop2_d;
  logic          tx_q, tx_d;

  logic          push;
  logic          pop;
  logic [7:0]    head;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign push    = wr_en && !full;
  assign head    = mem_q[rptr_q];
  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

  // Storage needs no reset: count and pointers define validity.
  always_ff @(posedge clk_50m) begin
    if (push) begin
      mem_q[wptr_q] <= din;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    sample_d = sample_q;
    bitpos_d = bitpos_q;
    stop2_d  = stop2_q;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clken && !empty) begin
          pop      = 1'b1;
          shreg_d  = head;
          sample_d = '0;
          state_d  = START;
        end
      end
      START: begin
        if (clken) begin
          sample_d = sample_q + 1'b1;
          if (sample_q == 4'd15) begin
            bitpos_d = '0;
            state_d  = DATA;
          end
        end
      end
      DATA: begin
        if (clken) begin
          sample_d = sample_q + 1'b1;
          if (sample_q == 4'd15) begin
            shreg_d  = {1'b0, shreg_q[7:1]};
            bitpos_d = bitpos_q + 1'b1;
            if (bitpos_q == 3'd7) begin
              stop2_d = 1'b0;
              state_d = STOP;
            end
          end
        end
      end
      STOP: begin
        if (clken) begin
          sample_d = sample_q + 1'b1;
          if (sample_q == 4'd15) begin
            if (TWO_STOP && !stop2_q) begin
              stop2_d = 1'b1;
            end else begin
              stop2_d = 1'b0;
              // Chain the next byte with no idle gap.
              if (!empty) begin
                pop     = 1'b1;
                shreg_d = head;
                state_d = START;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      shreg_q  <= '0;
      sample_q <= '0;
      bitpos_q <= '0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      sample_q <= sample_d;
      bitpos_q <= bitpos_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: random and directed stimulus against a
// frame-level model, for one and two stop bits.
module tb_transmitter;

  localparam int DEPTH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clken = 1'b0;
  logic [7:0] din   = 8'h00;
  logic       wr_en = 1'b0;

  int checks = 0;
  int errors = 0;

  int   bc [2];
  int   lc [2];
  int   fi [2];
  int   fh [2];
  logic hist [1024];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : m
    localparam int NS = g + 1;
    localparam int L  = 16 * (10 + g);

    logic tx_w, busy_w, full_w, empty_w;

    transmitter #(
      .FIFO_DEPTH(DEPTH),
      .STOP_BITS (NS)
    ) dut (
      .clk_50m(clk),
      .rst_n  (rst_n),
      .clken  (clken),
      .din    (din),
      .wr_en  (wr_en),
      .tx     (tx_w),
      .tx_busy(busy_w),
      .full   (full_w),
      .empty  (empty_w)
    );

    logic [7:0] fq [$];
    logic [7:0] cur = 8'h00;
    bit         on  = 1'b0;
    int         t   = 0;
    bit         e0, f0;

    // Frame-level view: t counts ticks elapsed in the current frame.
    function automatic logic etx();
      int b;
      if (!on) return 1'b1;
      b = t / 16;
      if (b == 0) return 1'b0;
      if (b <= 8) return cur[b-1];
      return 1'b1;
    endfunction

    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        fq.delete();
        on = 1'b0;
        t  = 0;
      end else begin
        e0 = (fq.size() == 0);
        f0 = (fq.size() == DEPTH);
        if (!on) begin
          if (clken && !e0) begin
            cur = fq.pop_front();
            on  = 1'b1;
            t   = 0;
          end
        end else if (clken) begin
          t++;
          if (t == L) begin
            if (!e0) begin
              cur = fq.pop_front();
              t   = 0;
            end else begin
              on = 1'b0;
            end
          end
        end
        if (wr_en && !f0) fq.push_back(din);
      end
    end

    initial forever begin
      logic [3:0] a, e;
      @(negedge clk);
      a = {tx_w, busy_w, full_w, empty_w};
      e = {etx(), on, fq.size() == DEPTH, fq.size() == 0};
      chk($sformatf("line_s%0d {tx,busy,full,empty}", NS), a, e);
    end
  end

  task automatic smp(input int k, input int i, input logic txv,
                     input logic bv);
    if (bv) bc[k]++;
    else if (fi[k] < 0) fi[k] = i;
    if (!txv) lc[k]++;
    else if (fh[k] < 0) fh[k] = i;
  endtask

  task automatic watch(input int n, input int pat);
    for (int k = 0; k < 2; k++) begin
      bc[k] = 0;
      lc[k] = 0;
      fi[k] = -1;
      fh[k] = -1;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      smp(0, i, m[0].tx_w, m[0].busy_w);
      smp(1, i, m[1].tx_w, m[1].busy_w);
      if (i < 1024) hist[i] = m[0].tx_w;
      if (pat == 2) clken = (i % 4 == 0);
    end
  endtask

  task automatic push1(input logic [7:0] b);
    @(negedge clk);
    din   = b;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rnd(input int n);
    int wp, cp;
    wp = 8;
    cp = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i % 500 == 0) begin
        wp = $urandom_range(2, 40);
        cp = $urandom_range(0, 3);
      end
      clken = (cp == 0) ? 1'b1 : ($urandom_range(0, cp) == 0);
      wr_en = ($urandom_range(0, wp - 1) == 0);
      din   = 8'($urandom);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    logic [9:0] ef;
    int cnt;
    ef = 10'b1101001010;

    repeat (3) @(negedge clk);
    chk("rst_tx", m[0].tx_w, 1);
    chk("rst_busy", m[0].busy_w, 0);
    chk("rst_full", m[0].full_w, 0);
    chk("rst_empty", m[0].empty_w, 1);
    rst_n = 1'b1;
    watch(20, 0);
    chk("idle_busy", bc[0], 0);

    // 0xA5, clken held high
    clken = 1'b1;
    push1(8'hA5);
    watch(200, 0);
    for (int b = 0; b < 10; b++) begin
      cnt = 0;
      for (int j = 0; j < 16; j++)
        if (hist[16*b+j] == ef[b]) cnt++;
      chk($sformatf("a5_bit%0d", b), cnt, 16);
    end
    chk("a5_busy_s1", bc[0], 160);
    chk("a5_run_s1", fi[0], 160);
    chk("a5_busy_s2", bc[1], 176);

    // 0x00, two stop bits
    push1(8'h00);
    watch(200, 0);
    chk("z_low_s2", fh[1], 144);
    chk("z_lowcnt_s2", lc[1], 144);
    chk("z_busy_s2", fi[1], 176);
    chk("z_busy_s1", fi[0], 160);

    // fill, overflow, push-while-full with pop
    clken = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) chk("fill_full4", m[0].full_w, 1);
      din   = 8'(17 * (k + 1));
      wr_en = 1'b1;
    end
    @(negedge clk);
    chk("fill_full5", m[0].full_w, 1);
    din   = 8'h66;
    wr_en = 1'b1;
    clken = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("pp_full", m[0].full_w, 0);
    chk("pp_empty", m[0].empty_w, 0);
    chk("pp_busy", m[0].busy_w, 1);
    watch(780, 0);
    chk("fill_run_s1", fi[0] + 1, 640);
    chk("fill_run_s2", fi[1] + 1, 704);
    chk("fill_empty", m[0].empty_w, 1);

    // 0xFF with clken every 4th cycle
    clken = 1'b0;
    push1(8'hFF);
    watch(800, 2);
    clken = 1'b0;
    chk("ff_start", lc[0], 64);
    chk("ff_frame_s1", bc[0], 640);
    chk("ff_frame_s2", bc[1], 704);

    // reset mid-frame with bytes queued
    clken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      din   = 8'h0F + 8'(k);
      wr_en = 1'b1;
    end
    @(negedge clk);
    wr_en = 1'b0;
    watch(40, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_tx", m[0].tx_w, 1);
    chk("mrst_busy", m[0].busy_w, 0);
    chk("mrst_empty", m[0].empty_w, 1);
    chk("mrst_full", m[0].full_w, 0);
    chk("mrst_busy_s2", m[1].busy_w, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch(400, 0);
    chk("post_busy", bc[0] + bc[1], 0);
    chk("post_low", lc[0] + lc[1], 0);

    // random traffic, then drain
    rnd(8000);
    clken = 1'b1;
    watch(2000, 0);
    chk("drain_empty", m[1].empty_w, 1);
    chk("drain_busy", m[1].busy_w, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
